// File: rtl/rvsteel_debouncer.sv
// rvsteel_debouncer
// Conditions board-level buttons and switches before they reach rvsteel_soc.
// Each channel is handled independently. The raw input passes through a
// synchroniser chain and an optional polarity inversion. A new level is then
// accepted only after it has held for STABLE_CYCLES consecutive clocks.
//
// Ports
//   clock     : single clock for all logic
//   reset     : asynchronous, active-high; clears all state immediately
//   raw_in    : asynchronous pad inputs, one bit per channel
//   debounced : filtered, post-inversion level per channel
//   rise      : one-cycle pulse after debounced[i] goes 0->1
//   fall      : one-cycle pulse after debounced[i] goes 1->0

module rvsteel_debouncer #(
    parameter int               WIDTH         = 2,
    parameter int               STABLE_CYCLES = 120000,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] INVERT        = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       count_q;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   sample;
        logic                   accept;

        // Sync stages reset to the pad level that corresponds to RESET_VALUE.
        // This stops reset release from looking like an input transition.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_VALUE[i] ^ INVERT[i]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        assign sample = sync_q[SYNC_STAGES-1] ^ INVERT[i];
        assign accept = (sample != level_q) && (count_q == TERMINAL);

        // Any sample that matches the current level restarts qualification.
        // The terminal count always flips the level and clears the counter,
        // so the counter never wraps.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count_q <= '0;
                level_q <= RESET_VALUE[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= accept && sample;
                fall_q <= accept && !sample;
                if (sample == level_q) begin
                    count_q <= '0;
                end else if (accept) begin
                    level_q <= sample;
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end

        assign debounced[i] = level_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;
    end

endmodule

// File: tb/tb_rvsteel_debouncer.sv
// tb_rvsteel_debouncer
// Directed bench for rvsteel_debouncer, using STABLE_CYCLES=4 and SYNC_STAGES=2.
// Two instances are used:
//   dut_a : non-inverted channels, RESET_VALUE=2'b10
//   dut_b : channel 0 inverted (active-low), RESET_VALUE=2'b00
// The expected {debounced, rise, fall} is queued when each step is driven.
// It is popped and compared once the clock edge has produced the output.

module tb_rvsteel_debouncer;

    logic       clock;
    logic       reset;
    logic [1:0] raw_a, deb_a, rise_a, fall_a;
    logic [1:0] raw_b, deb_b, rise_b, fall_b;

    rvsteel_debouncer #(
        .WIDTH(2), .STABLE_CYCLES(4), .SYNC_STAGES(2),
        .INVERT(2'b00), .RESET_VALUE(2'b10)
    ) dut_a (
        .clock(clock), .reset(reset), .raw_in(raw_a),
        .debounced(deb_a), .rise(rise_a), .fall(fall_a)
    );

    rvsteel_debouncer #(
        .WIDTH(2), .STABLE_CYCLES(4), .SYNC_STAGES(2),
        .INVERT(2'b01), .RESET_VALUE(2'b00)
    ) dut_b (
        .clock(clock), .reset(reset), .raw_in(raw_b),
        .debounced(deb_b), .rise(rise_b), .fall(fall_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string      tag;
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0] ea_deb, ea_rise, ea_fall;
    logic [1:0] eb_deb, eb_rise, eb_fall;

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.a   = {ea_deb, ea_rise, ea_fall};
        e.b   = {eb_deb, eb_rise, eb_fall};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [5:0] obs_a;
        logic [5:0] obs_b;
        e     = sb.pop_front();
        obs_a = {deb_a, rise_a, fall_a};
        obs_b = {deb_b, rise_b, fall_b};
        checks++;
        assert (obs_a === e.a) else begin
            errors++;
            $error("FAIL %s dut_a {deb,rise,fall}: observed %b expected %b", e.tag, obs_a, e.a);
        end
        checks++;
        assert (obs_b === e.b) else begin
            errors++;
            $error("FAIL %s dut_b {deb,rise,fall}: observed %b expected %b", e.tag, obs_b, e.b);
        end
    endtask

    task automatic tick(input string tag);
        push_exp(tag);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic check_now(input string tag);
        push_exp(tag);
        pop_check();
    endtask

    initial begin
        reset   = 1'b1;
        raw_a   = 2'b10;
        raw_b   = 2'b01;
        ea_deb  = 2'b10; ea_rise = 2'b00; ea_fall = 2'b00;
        eb_deb  = 2'b00; eb_rise = 2'b00; eb_fall = 2'b00;

        // reset state and quiet release
        #12;
        check_now("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        ticks(20, "post_reset");

        // clean press and release on dut_a channel 0: six-edge latency
        raw_a = 2'b11;
        ticks(5, "press_wait");
        ea_deb = 2'b11; ea_rise = 2'b01;
        tick("press_rise");
        ea_rise = 2'b00;
        ticks(3, "press_hold");
        raw_a = 2'b10;
        ticks(5, "release_wait");
        ea_deb = 2'b10; ea_fall = 2'b01;
        tick("release_fall");
        ea_fall = 2'b00;
        ticks(3, "release_hold");

        // bounce: high 3, low 1, high 3, low -> rejected
        raw_a = 2'b11; ticks(3, "bounce_h1");
        raw_a = 2'b10; tick("bounce_l1");
        raw_a = 2'b11; ticks(3, "bounce_h2");
        raw_a = 2'b10; ticks(6, "bounce_low");
        // then a steady 10-cycle press -> one rise
        raw_a = 2'b11;
        ticks(5, "steady_wait");
        ea_deb = 2'b11; ea_rise = 2'b01;
        tick("steady_rise");
        ea_rise = 2'b00;
        ticks(4, "steady_hold");
        raw_a = 2'b10;
        ticks(5, "steady_rel_wait");
        ea_deb = 2'b10; ea_fall = 2'b01;
        tick("steady_fall");
        ea_fall = 2'b00;
        ticks(2, "steady_idle");

        // inversion: dut_b channel 0 idles high, pressing pulls it low
        raw_b = 2'b00;
        ticks(5, "inv_wait");
        eb_deb = 2'b01; eb_rise = 2'b01;
        tick("inv_rise");
        eb_rise = 2'b00;
        ticks(2, "inv_hold");
        raw_b = 2'b01;
        ticks(5, "inv_rel_wait");
        eb_deb = 2'b00; eb_fall = 2'b01;
        tick("inv_fall");
        eb_fall = 2'b00;
        ticks(2, "inv_idle");

        // channel independence: ch0 rises cleanly; ch1 falls with one bounce
        raw_a = 2'b01; ticks(2, "indep_t1_2");
        raw_a = 2'b11; tick("indep_t3_bounce");
        raw_a = 2'b01; ticks(2, "indep_t4_5");
        ea_deb = 2'b11; ea_rise = 2'b01;
        tick("indep_ch0_rise");
        ea_rise = 2'b00;
        ticks(2, "indep_t7_8");
        ea_deb = 2'b01; ea_fall = 2'b10;
        tick("indep_ch1_fall");
        ea_fall = 2'b00;
        ticks(2, "indep_idle");
        // both channels flip on the same edge, in opposite directions
        raw_a = 2'b10;
        ticks(5, "swap_wait");
        ea_deb = 2'b10; ea_rise = 2'b10; ea_fall = 2'b01;
        tick("swap_pulses");
        ea_rise = 2'b00; ea_fall = 2'b00;
        ticks(2, "swap_idle");

        // reset mid-qualification: counter lost, restart from release
        raw_a = 2'b11;
        ticks(3, "midcount_pre");
        reset = 1'b1;
        #1;
        check_now("midcount_in_reset");
        reset = 1'b0;
        ticks(5, "midcount_wait");
        ea_deb = 2'b11; ea_rise = 2'b01;
        tick("midcount_rise");
        ea_rise = 2'b00;
        ticks(2, "midcount_hold");

        // reset asserted during a pulse cycle drops the pulse at once
        raw_a = 2'b10;
        ticks(5, "pulse_rst_wait");
        ea_deb = 2'b10; ea_fall = 2'b01;
        tick("pulse_rst_fall");
        reset = 1'b1;
        #1;
        ea_fall = 2'b00;
        check_now("pulse_rst_dropped");
        reset = 1'b0;
        ticks(5, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvsteel_debouncer.md
# rvsteel_debouncer

Parametrised multi-channel input conditioner for board-level buttons and switches on RISC-V Steel FPGA top levels (reset, halt, GPIO inputs). Each channel passes through a multi-stage synchroniser, optional polarity inversion and a counter-based stability filter. The block drives a clean level plus single-cycle rise/fall pulses. It sits between the pads and `rvsteel_soc` and replaces ad-hoc single-flop registering of button inputs.

## Interface
- `WIDTH`, default 2: number of independent channels (≥1).
- `STABLE_CYCLES`, default 120000: cycles an input must hold a new value before it is accepted. Default is 10 ms at 12 MHz. Must be ≥1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `INVERT`, default {WIDTH{1'b0}}: per-channel mask. A 1 inverts the raw pad (active-low button).
- `RESET_VALUE`, default {WIDTH{1'b0}}: per-channel post-inversion level loaded into `debounced` at reset.
- `clock` input 1: single clock for all logic.
- `reset` input 1: asynchronous, active-high; asserted for any duration, clears state immediately.
- `raw_in` input WIDTH: asynchronous pad inputs.
- `debounced` output WIDTH: filtered, post-inversion level per channel.
- `rise` output WIDTH: one-cycle pulse when `debounced[i]` goes 0→1.
- `fall` output WIDTH: one-cycle pulse when `debounced[i]` goes 1→0.

## Operation
- Channels are fully independent; no shared counter.
- Synchroniser: chain of SYNC_STAGES flops on `raw_in[i]`. Reset value of every stage is `RESET_VALUE[i] ^ INVERT[i]`, so release of reset never creates a phantom transition.
- `sample[i]` = last sync stage XOR `INVERT[i]`.
- Counter per channel, width `$clog2(STABLE_CYCLES)` (minimum 1 bit).
- On each rising edge:
  - If `sample[i] == debounced[i]`, the counter clears to 0 (glitch rejection: any return to the current level restarts qualification).
  - If `sample[i] != debounced[i]` and the counter is below STABLE_CYCLES-1, the counter increments.
  - If `sample[i] != debounced[i]` and the counter equals STABLE_CYCLES-1, `debounced[i]` takes `sample[i]` and the counter clears.
- `rise[i]`/`fall[i]` are registered. They are high exactly in the cycle following the edge on which `debounced[i]` changed, and low otherwise. They are never both high on one channel.
- The counter never wraps: the terminal condition always flips the level and clears the counter.
- STABLE_CYCLES=1: the level follows `sample` on the first mismatching edge, which amounts to a pure synchroniser plus one register.

## Timing
- Reset values, applied asynchronously while `reset` is high:
  - `debounced` = RESET_VALUE
  - `rise` = `fall` = 0
  - counters = 0
  - sync stages = RESET_VALUE ^ INVERT
- Latency: let the raw input take its new value before rising edge k and hold it. `debounced` changes at edge k+SYNC_STAGES+STABLE_CYCLES-1, i.e. the (SYNC_STAGES+STABLE_CYCLES)-th edge counting k as the first. The `rise`/`fall` pulse is visible in the following cycle.
- A pulse shorter than STABLE_CYCLES cycles at the synchroniser output produces no output change and no pulse.
- Reset mid-qualification: the counter is lost. After release, qualification starts from 0 against RESET_VALUE.
- Reset asserted during a pulse cycle: the pulse drops immediately (asynchronously).
- Simultaneous changes on several channels are handled in parallel with identical latency.
- Outputs are glitch-free registers and safe to feed into the SoC `reset`/`halt` directly.

## Test plan
- Reset check (WIDTH=2, RESET_VALUE=2'b10, INVERT=2'b00): hold `reset`, drive `raw_in`=2'b10, release → `debounced`=2'b10, `rise`=`fall`=0 for 20 cycles, no pulses.
- Clean press (STABLE_CYCLES=4, SYNC_STAGES=2): `raw_in[0]` 0→1 before edge k → `debounced[0]`=1 after edge k+5, `rise[0]`=1 for exactly one cycle after it. Release 1→0 → `fall[0]` pulse with the same 6-edge latency.
- Bounce rejection (STABLE_CYCLES=4): toggle `raw_in[0]` high 3 cycles, low 1, high 3, low → `debounced[0]` stays 0, no `rise`. Then hold high 10 cycles → a single `rise`.
- Inversion (INVERT=2'b01, RESET_VALUE=0): `raw_in[0]` idles high → `debounced[0]`=0. Drive low → `debounced[0]`=1 after 6 edges with a `rise[0]` pulse.
- Channel independence: change both channels on the same edge, channel 1 bouncing → channel 0 settles at k+5 while channel 1 follows its own stable window; pulses do not cross channels.
- Reset mid-count: `raw_in[0]` goes high, assert `reset` after 3 cycles, release → `debounced[0]`=0 at release, then becomes 1 six edges after release with one `rise[0]`.
